// File: rtl/mult_pkg.sv
// Shared types and constants for the 8-bit signed add-shift multiplier.
// The width is fixed by the 9-bit adder stage this control block feeds.
package mult_pkg;

   localparam int unsigned N_BITS    = 8;
   localparam logic [2:0]  LAST_ITER = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      SHIFT,
      HOLD
   } state_t;

endpackage

// File: rtl/mult_shift_ctrl.sv
// Control and register stage of the signed add-shift multiplier: holds X/A/B/S,
// feeds the external 9-bit adder, and sequences 8 add/shift iterations.
module mult_shift_ctrl
   import mult_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Run,
   input  logic              ClearA_LoadB,
   input  logic [N_BITS-1:0] Sw,
   input  logic [N_BITS-1:0] A_new,
   input  logic              X_in,
   output logic [N_BITS-1:0] Add_A,
   output logic [N_BITS-1:0] Add_S,
   output logic [N_BITS-1:0] Aval,
   output logic [N_BITS-1:0] Bval,
   output logic              Xval,
   output logic              Busy,
   output logic              Done
);

   localparam logic [N_BITS-1:0] MOST_NEG = {1'b1, {(N_BITS-1){1'b0}}};

   state_t            state;
   logic [2:0]        cnt;
   logic              x;
   logic [N_BITS-1:0] a;
   logic [N_BITS-1:0] b;
   logic [N_BITS-1:0] s;
   logic              last_iter;

   assign last_iter = (cnt == LAST_ITER);

   // The sign bit of B carries negative weight, so the final step subtracts S.
   assign Add_S = last_iter ? (~s + N_BITS'(1)) : s;
   assign Add_A = a;
   assign Aval  = a;
   assign Bval  = b;
   assign Xval  = x;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         x     <= 1'b0;
         a     <= '0;
         b     <= '0;
         s     <= '0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ClearA_LoadB) begin
                  x <= 1'b0;
                  a <= '0;
                  b <= Sw;
               end else if (Run) begin
                  s     <= Sw;
                  x     <= 1'b0;
                  a     <= '0;
                  cnt   <= '0;
                  state <= ADD;
                  Busy  <= 1'b1;
               end
            end
            ADD: begin
               if (b[0]) begin
                  a <= A_new;
                  // Negating -128 overflows the adder's sign extension; A+128 is never negative.
                  x <= (last_iter && s == MOST_NEG) ? 1'b0 : X_in;
               end
               state <= SHIFT;
            end
            SHIFT: begin
               a <= {x, a[N_BITS-1:1]};
               b <= {a[0], b[N_BITS-1:1]};
               if (last_iter) begin
                  state <= HOLD;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
               end else begin
                  cnt   <= cnt + 3'd1;
                  state <= ADD;
               end
            end
            HOLD: begin
               if (!Run) begin
                  state <= IDLE;
                  Done  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_shift_ctrl.sv
// Self-checking bench for mult_shift_ctrl with a behavioural 9-bit adder and
// a transaction-level model that predicts the product by plain signed multiply.
module tb_mult_shift_ctrl;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Run = 1'b0;
   logic       ClearA_LoadB = 1'b0;
   logic [7:0] Sw = '0;
   logic [7:0] A_new;
   logic       X_in;
   logic [7:0] Add_A, Add_S, Aval, Bval;
   logic       Xval, Busy, Done;
   logic [8:0] sum;

   mult_shift_ctrl dut (
      .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
      .Sw(Sw), .A_new(A_new), .X_in(X_in), .Add_A(Add_A), .Add_S(Add_S),
      .Aval(Aval), .Bval(Bval), .Xval(Xval), .Busy(Busy), .Done(Done)
   );

   // Sign-extending 9-bit adder stage
   assign sum   = {Add_A[7], Add_A} + {Add_S[7], Add_S};
   assign A_new = sum[7:0];
   assign X_in  = sum[8];

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: 0 idle, 1 busy, 2 hold
   int                 m_st;
   int                 m_ctr;
   logic               m_neg;
   logic [7:0]         m_a, m_b, m_s, m_b0;
   logic               m_x;
   logic signed [15:0] m_p;
   logic [7:0]         exp_s;

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         m_st = 0; m_ctr = 0; m_neg = 1'b0;
         m_a = '0; m_b = '0; m_s = '0; m_b0 = '0; m_x = 1'b0;
      end else begin
         case (m_st)
            0: begin
               if (ClearA_LoadB) begin
                  m_a = '0; m_x = 1'b0; m_b = Sw;
               end else if (Run) begin
                  m_s = Sw; m_b0 = m_b; m_a = '0; m_x = 1'b0;
                  m_ctr = 0; m_neg = 1'b0; m_st = 1;
               end
            end
            1: begin
               m_ctr++;
               if (m_ctr >= 14) m_neg = 1'b1;
               if (m_ctr == 16) begin
                  m_p = $signed(m_s) * $signed(m_b0);
                  m_a = m_p[15:8];
                  m_b = m_p[7:0];
                  m_x = m_p[15];
                  m_st = 2;
               end
            end
            default: if (!Run) m_st = 0;
         endcase
      end
   end

   always @(negedge Clk) begin
      exp_s = m_neg ? (~m_s + 8'd1) : m_s;
      check("busy", 16'(Busy), 16'(m_st == 1));
      check("done", 16'(Done), 16'(m_st == 2));
      check("add_a", 16'(Add_A), 16'(Aval));
      check("add_s", 16'(Add_S), 16'(exp_s));
      if (m_st != 1) begin
         check("aval", 16'(Aval), 16'(m_a));
         check("bval", 16'(Bval), 16'(m_b));
         check("xval", 16'(Xval), 16'(m_x));
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic load(input logic [7:0] v);
      ClearA_LoadB = 1'b1;
      Sw = v;
      tick();
      ClearA_LoadB = 1'b0;
      Sw = 8'($urandom);
   endtask

   task automatic mult(input logic [7:0] v, input int hold, input bit noise);
      int n;
      n = 0;
      Run = 1'b1;
      Sw = v;
      tick();
      while (Busy && n < 40) begin
         n++;
         if (noise) begin
            ClearA_LoadB = 1'($urandom);
            Sw = 8'($urandom);
         end
         tick();
      end
      ClearA_LoadB = 1'b0;
      check("busy_cycles", 16'(n), 16'd16);
      check("done_after_busy", 16'(Done), 16'd1);
      repeat (hold) tick();
      if (hold > 0) check("held_done", 16'(Done), 16'd1);
      Run = 1'b0;
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) tick();
      check("rst_aval", 16'(Aval), 16'h0);
      check("rst_bval", 16'(Bval), 16'h0);
      check("rst_xval", 16'(Xval), 16'h0);
      check("rst_busy", 16'(Busy), 16'h0);
      check("rst_done", 16'(Done), 16'h0);
      check("rst_add_s", 16'(Add_S), 16'h0);
      Reset_n = 1'b1;
      tick();

      load(8'h3B);
      mult(8'h07, 0, 1);
      check("p_7x59", {Aval, Bval}, 16'h019D);
      check("x_7x59", 16'(Xval), 16'h0);

      mult(8'hFF, 0, 1);
      check("p_m1xm99", {Aval, Bval}, 16'h0063);

      load(8'hF9);
      mult(8'h3B, 0, 0);
      check("p_59xm7", {Aval, Bval}, 16'hFE63);
      check("x_59xm7", 16'(Xval), 16'h1);

      mult(8'hFF, 40, 1);
      check("p_reuse_b", {Aval, Bval}, 16'hFF9D);
      check("x_reuse_b", 16'(Xval), 16'h1);

      load(8'h80);
      mult(8'h80, 40, 1);
      check("p_m128sq", {Aval, Bval}, 16'h4000);
      check("x_m128sq", 16'(Xval), 16'h0);

      ClearA_LoadB = 1'b1;
      Run = 1'b1;
      Sw = 8'h5A;
      tick();
      ClearA_LoadB = 1'b0;
      Run = 1'b0;
      check("clr_prio_b", 16'(Bval), 16'h005A);
      check("clr_prio_busy", 16'(Busy), 16'h0);
      tick();
      check("clr_prio_busy2", 16'(Busy), 16'h0);

      load(8'h11);
      Run = 1'b1;
      Sw = 8'h22;
      tick();
      repeat (8) tick();
      check("mid_busy", 16'(Busy), 16'h1);
      #2 Reset_n = 1'b0;
      #1;
      check("arst_aval", 16'(Aval), 16'h0);
      check("arst_bval", 16'(Bval), 16'h0);
      check("arst_xval", 16'(Xval), 16'h0);
      check("arst_busy", 16'(Busy), 16'h0);
      check("arst_add_s", 16'(Add_S), 16'h0);
      Run = 1'b0;
      tick();
      Reset_n = 1'b1;
      tick();
      load(8'h22);
      mult(8'h11, 0, 1);
      check("p_after_rst", {Aval, Bval}, 16'h0242);

      for (int i = 0; i < 150; i++) begin
         if (($urandom % 4) != 0) load(8'($urandom));
         mult(8'($urandom), int'($urandom % 3), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
